// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared constants for the EX-stage divider sequencing controller:
//   - reset level and divider handshake levels
//   - controller state encoding (DivCtrlIdle/Busy/Done/Abort)
package div_ctrl_pkg;

    localparam logic RstEnable      = 1'b1;   // rst level that resets
    localparam logic DivStart       = 1'b1;   // divider start_i: run
    localparam logic DivStop        = 1'b0;   // divider start_i: release
    localparam logic DivResultReady = 1'b1;   // divider ready_o: result valid

    typedef enum logic [1:0] {
        DivCtrlIdle  = 2'd0,
        DivCtrlBusy  = 2'd1,
        DivCtrlDone  = 2'd2,
        DivCtrlAbort = 2'd3
    } div_ctrl_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if
// Handshake bundle between the sequencing controller and the multi-cycle
// divider.
//   div_start  : controller -> divider, start_i (DivStart/DivStop)
//   div_annul  : controller -> divider, annul_i (abort current division)
//   div_signed : controller -> divider, signed_div_i
//   div_op1    : controller -> divider, opdata1_i (dividend)
//   div_op2    : controller -> divider, opdata2_i (divisor)
//   div_result : divider -> controller, {remainder, quotient}
//   div_ready  : divider -> controller, result valid
// Modports: master = controller side, slave = divider side.
interface div_ctrl_if;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] div_result;
    logic        div_ready;

    modport master (
        output div_start, div_annul, div_signed, div_op1, div_op2,
        input  div_result, div_ready
    );

    modport slave (
        input  div_start, div_annul, div_signed, div_op1, div_op2,
        output div_result, div_ready
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl
// Sequences a DIV/DIVU from EX through the multi-cycle divider: latches the
// operands, holds start high while the divider runs, stalls the pipeline
// until the result is available, holds the result while EX is stalled and
// aborts a hung division with a watchdog.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   div_req_i        : EX holds a DIV/DIVU
//   signed_i         : 1 = DIV, 0 = DIVU
//   op1_i, op2_i     : dividend / divisor from EX
//   flush_i          : pipeline flush
//   stall_i          : EX held by a later stage
//   stallreq_o       : stall request at EX
//   result_o         : {remainder, quotient}
//   result_valid_o   : result_o valid for the instruction in EX
//   busy_o           : controller not idle
//   timeout_o        : sticky watchdog-abort flag
//   div_if           : divider handshake (master side)
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_req_i,
    input  logic             signed_i,
    input  logic [31:0]      op1_i,
    input  logic [31:0]      op2_i,
    input  logic             flush_i,
    input  logic             stall_i,
    output logic             stallreq_o,
    output logic [63:0]      result_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             timeout_o,
    div_ctrl_if.master       div_if
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    div_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic             signed_q, signed_d;
    logic [63:0]      result_q, result_d;
    logic             timeout_q, timeout_d;

    logic             stallreq;
    logic             start;
    logic             annul;
    logic             result_valid;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= DivCtrlIdle;
            cnt_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            signed_q  <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            signed_q  <= signed_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        signed_d     = signed_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        stallreq     = 1'b0;
        start        = DivStop;
        annul        = 1'b0;
        result_valid = 1'b0;

        // Strobes are suppressed while rst is high: the divider shares the
        // reset, so an annul pulse here would be redundant.
        if (rst != RstEnable) begin
            unique case (state_q)
                DivCtrlIdle: begin
                    if (div_req_i && !flush_i) begin
                        op1_d    = op1_i;
                        op2_d    = op2_i;
                        signed_d = signed_i;
                        stallreq = 1'b1;
                        cnt_d    = '0;
                        state_d  = DivCtrlBusy;
                    end
                end
                DivCtrlBusy: begin
                    start    = DivStart;
                    stallreq = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    // A flush beats a result arriving in the same cycle.
                    if (flush_i) begin
                        annul   = 1'b1;
                        state_d = DivCtrlAbort;
                    end else if (div_if.div_ready == DivResultReady) begin
                        result_d = div_if.div_result;
                        state_d  = DivCtrlDone;
                    end else if (cnt_q == CntLast) begin
                        // Hung divider: hand EX a zero result so it can retire.
                        annul     = 1'b1;
                        timeout_d = 1'b1;
                        result_d  = '0;
                        state_d   = DivCtrlDone;
                    end
                end
                DivCtrlDone: begin
                    result_valid = !flush_i;
                    if (flush_i || !stall_i) begin
                        state_d = DivCtrlIdle;
                    end
                end
                DivCtrlAbort: begin
                    // One quiet cycle lets the divider settle in its free state.
                    state_d = DivCtrlIdle;
                end
                default: begin
                    state_d = DivCtrlIdle;
                end
            endcase
        end
    end

    assign stallreq_o        = stallreq;
    assign result_o          = result_q;
    assign result_valid_o    = result_valid;
    assign busy_o            = (state_q != DivCtrlIdle);
    assign timeout_o         = timeout_q;
    assign div_if.div_start  = start;
    assign div_if.div_annul  = annul;
    assign div_if.div_signed = signed_q;
    assign div_if.div_op1    = op1_q;
    assign div_if.div_op2    = op2_q;

endmodule
